// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter arbiter slice:
// opcode encoding and default sizing.
package counter_arbiter_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 16;
    localparam int OPW       = 2;

    typedef enum logic [OPW-1:0] {
        OP_READ  = 2'b00,
        OP_INC   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Round-robin grant logic: one-hot grant from req,
// searching upward from ptr, plus the ptr register.
module rr_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clock,
    input  logic            resetN,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // First asserted req at or above ptr (wrapping) wins;
    // nothing is granted while reset is held.
    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        logic           found;
        gnt     = '0;
        gnt_id  = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = idx[IDW-1:0];
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_id   = sel;
                found    = 1'b1;
            end
        end
        if (!resetN) begin
            gnt    = '0;
            gnt_id = '0;
            found  = 1'b0;
        end
        gnt_any = found;
    end

    // Pointer moves just past the winner; idle cycles hold it.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (gnt_id == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Shared counter with round-robin access: decodes the
// granted op onto the counter and returns the old value.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       run,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][OPW-1:0]   op,
    input  logic [NREQ-1:0][WIDTH-1:0] wdata,
    output logic [NREQ-1:0]            gnt,
    output logic                       ack_valid,
    output logic [IDW-1:0]             ack_id,
    output logic [WIDTH-1:0]           rdata,
    output logic [WIDTH-1:0]           count,
    output logic                       wrap
);

    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ack_valid_q;
    logic             ack_valid_d;
    logic [IDW-1:0]   ack_id_q;
    logic [IDW-1:0]   ack_id_d;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    op_e              op_sel;
    logic [WIDTH-1:0] wsel;
    logic             do_inc;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clock   (clock),
        .resetN  (resetN),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // Op decode: modifying ops override run, and at most one
    // increment source applies, so the step never exceeds +1.
    always_comb begin
        count_d = count_q;
        do_inc  = 1'b0;
        op_sel  = op_e'(op[gnt_id]);
        wsel    = wdata[gnt_id];
        if (gnt_any) begin
            unique case (op_sel)
                OP_READ:  do_inc  = run;
                OP_INC:   do_inc  = 1'b1;
                OP_LOAD:  count_d = wsel;
                OP_CLEAR: count_d = '0;
            endcase
        end else begin
            do_inc = run;
        end
        if (do_inc) begin
            count_d = count_q + 1'b1;
        end
        wrap_d = do_inc && (&count_q);
    end

    // Acknowledge side: flag, winner id and pre-op count.
    always_comb begin
        ack_valid_d = gnt_any;
        ack_id_d    = ack_id_q;
        rdata_d     = rdata_q;
        if (gnt_any) begin
            ack_id_d = gnt_id;
            rdata_d  = count_q;
        end
    end

    // State registers; reset drops any in-flight grant.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q     <= '0;
            wrap_q      <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_id_q    <= '0;
            rdata_q     <= '0;
        end else begin
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            ack_valid_q <= ack_valid_d;
            ack_id_q    <= ack_id_d;
            rdata_q     <= rdata_d;
        end
    end

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign ack_valid = ack_valid_q;
    assign ack_id    = ack_id_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed vector table,
// reset corner cases and randomized model comparison.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic                 clock = 1'b0;
    logic                 resetN;
    logic                 run;
    logic [N-1:0]         req;
    logic [N-1:0][1:0]    op;
    logic [N-1:0][W-1:0]  wdata;
    logic [N-1:0]         gnt;
    logic                 ack_valid;
    logic [1:0]           ack_id;
    logic [W-1:0]         rdata;
    logic [W-1:0]         count;
    logic                 wrap;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    counter_arbiter #(
        .NREQ  (N),
        .WIDTH (W)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .run       (run),
        .req       (req),
        .op        (op),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .rdata     (rdata),
        .count     (count),
        .wrap      (wrap)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        run;
        logic [3:0]  req;
        logic [7:0]  op;
        logic [15:0] wd;
        logic [3:0]  gnt;
        logic [15:0] cnt;
        logic        ackv;
        logic [1:0]  id;
        logic [15:0] rd;
        logic        wrap;
    } vec_t;

    vec_t tv[20];

    bit          pend[N];
    logic [1:0]  pop[N];
    logic [15:0] pwd[N];

    initial begin
        int m_count;
        int m_ptr;
        int g;
        int nxt;
        bit inc;
        int e_rd;

        tv[0]  = '{0, 4'b0001, 8'h02, 16'hFFFE, 4'b0001, 16'hFFFE, 1, 0, 16'h0000, 0};
        tv[1]  = '{1, 4'b0000, 8'h00, 16'h0000, 4'b0000, 16'hFFFF, 0, 0, 16'h0000, 0};
        tv[2]  = '{1, 4'b0000, 8'h00, 16'h0000, 4'b0000, 16'h0000, 0, 0, 16'h0000, 1};
        tv[3]  = '{0, 4'b1000, 8'h00, 16'h0000, 4'b1000, 16'h0000, 1, 3, 16'h0000, 0};
        tv[4]  = '{1, 4'b1111, 8'h00, 16'h0000, 4'b0001, 16'h0001, 1, 0, 16'h0000, 0};
        tv[5]  = '{1, 4'b1111, 8'h00, 16'h0000, 4'b0010, 16'h0002, 1, 1, 16'h0001, 0};
        tv[6]  = '{1, 4'b1111, 8'h00, 16'h0000, 4'b0100, 16'h0003, 1, 2, 16'h0002, 0};
        tv[7]  = '{1, 4'b1111, 8'h00, 16'h0000, 4'b1000, 16'h0004, 1, 3, 16'h0003, 0};
        tv[8]  = '{1, 4'b1111, 8'h00, 16'h0000, 4'b0001, 16'h0005, 1, 0, 16'h0004, 0};
        tv[9]  = '{1, 4'b0010, 8'h08, 16'h000A, 4'b0010, 16'h000A, 1, 1, 16'h0005, 0};
        tv[10] = '{1, 4'b0100, 8'h20, 16'h1234, 4'b0100, 16'h1234, 1, 2, 16'h000A, 0};
        tv[11] = '{1, 4'b0001, 8'h01, 16'h0000, 4'b0001, 16'h1235, 1, 0, 16'h1234, 0};
        tv[12] = '{0, 4'b0011, 8'h0D, 16'h0000, 4'b0010, 16'h0000, 1, 1, 16'h1235, 0};
        tv[13] = '{0, 4'b0011, 8'h0D, 16'h0000, 4'b0001, 16'h0001, 1, 0, 16'h0000, 0};
        tv[14] = '{0, 4'b0001, 8'h02, 16'hFFFF, 4'b0001, 16'hFFFF, 1, 0, 16'h0001, 0};
        tv[15] = '{1, 4'b1000, 8'hC0, 16'h0000, 4'b1000, 16'h0000, 1, 3, 16'hFFFF, 0};
        tv[16] = '{0, 4'b0100, 8'h20, 16'hFFFF, 4'b0100, 16'hFFFF, 1, 2, 16'h0000, 0};
        tv[17] = '{1, 4'b0100, 8'h10, 16'h0000, 4'b0100, 16'h0000, 1, 2, 16'hFFFF, 1};
        tv[18] = '{0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 16'h0000, 0, 0, 16'h0000, 0};
        tv[19] = '{0, 4'b0001, 8'h02, 16'h0000, 4'b0001, 16'h0000, 1, 0, 16'h0000, 0};

        // reset at time zero
        resetN = 1'b0;
        run    = 1'b0;
        req    = '0;
        op     = '0;
        wdata  = '0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ackv", ack_valid, 0);
        chk("rst_gnt", gnt, 0);
        #1 resetN = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_count", count, 0);
        chk("post_rst_ackv", ack_valid, 0);
        chk("post_rst_wrap", wrap, 0);

        // directed vector table
        for (int v = 0; v < 20; v++) begin
            run = tv[v].run;
            req = tv[v].req;
            op  = tv[v].op;
            for (int i = 0; i < N; i++) wdata[i] = tv[v].wd;
            #1;
            chk($sformatf("v%0d_gnt", v), gnt, tv[v].gnt);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_count", v), count, tv[v].cnt);
            chk($sformatf("v%0d_ackv", v), ack_valid, tv[v].ackv);
            chk($sformatf("v%0d_wrap", v), wrap, tv[v].wrap);
            if (tv[v].ackv) begin
                chk($sformatf("v%0d_id", v), ack_id, tv[v].id);
                chk($sformatf("v%0d_rdata", v), rdata, tv[v].rd);
            end
        end

        // reset in the middle of a pending op from requester 1
        run = 1'b0;
        req = 4'b0010;
        op  = 8'h08;
        for (int i = 0; i < N; i++) wdata[i] = 16'h5555;
        #1;
        chk("mid_load_gnt", gnt, 4'b0010);
        @(posedge clock);
        #1;
        chk("mid_load_count", count, 16'h5555);
        chk("mid_load_ackv", ack_valid, 1);
        chk("mid_load_id", ack_id, 1);
        op = 8'h04;
        #1;
        chk("mid_inc_gnt", gnt, 4'b0010);
        #1 resetN = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ackv", ack_valid, 0);
        chk("mid_rst_id", ack_id, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_gnt", gnt, 0);
        @(posedge clock);
        #1;
        chk("mid_hold_count", count, 0);
        chk("mid_hold_ackv", ack_valid, 0);
        resetN = 1'b1;
        #1;
        chk("mid_rel_gnt", gnt, 4'b0010);
        chk("mid_rel_ackv", ack_valid, 0);
        @(posedge clock);
        #1;
        chk("mid_rel_count", count, 1);
        chk("mid_rel_ackv2", ack_valid, 1);
        chk("mid_rel_id", ack_id, 1);
        chk("mid_rel_rdata", rdata, 0);

        // randomized traffic against a reference model
        m_count = 1;
        m_ptr   = 2;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pop[i]  = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) == 0)
                        pwd[i] = 16'hFFFF - 16'($urandom_range(0, 3));
                    else
                        pwd[i] = 16'($urandom);
                end
            end
            run = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req[i]   = pend[i];
                op[i]    = pop[i];
                wdata[i] = pwd[i];
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            #1;
            chk("rnd_gnt", gnt, (g < 0) ? 0 : (1 << g));
            nxt  = m_count;
            inc  = run;
            e_rd = m_count;
            if (g >= 0) begin
                case (pop[g])
                    2'd0: inc = run;
                    2'd1: inc = 1'b1;
                    2'd2: begin inc = 1'b0; nxt = int'(pwd[g]); end
                    default: begin inc = 1'b0; nxt = 0; end
                endcase
                m_ptr = (g + 1) % N;
            end
            if (inc) nxt = (m_count + 1) % 65536;
            @(posedge clock);
            #1;
            chk("rnd_count", count, nxt);
            chk("rnd_ackv", ack_valid, (g >= 0) ? 1 : 0);
            chk("rnd_wrap", wrap, (inc && nxt == 0) ? 1 : 0);
            if (g >= 0) begin
                chk("rnd_id", ack_id, g);
                chk("rnd_rdata", rdata, e_rd);
                if ($urandom_range(0, 3) == 0) begin
                    pop[g] = 2'($urandom_range(0, 3));
                    pwd[g] = 16'($urandom);
                end else begin
                    pend[g] = 1'b0;
                end
            end
            m_count = nxt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
